barrett_precompute_64b: RTL and testbench
=========================================

BARRETT_PRECOMPUTE_64B -- requirements
Module: barrett_precompute_64b

Interface
REQ-001 SHALL have parameter DATA_W, default 64: modulus width.
REQ-002 SHALL have port iClk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port iRstN, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port iClr, input, 1: synchronous clear, same effect as reset.
REQ-005 SHALL have port iStart, input, 1: request a new precompute.
REQ-006 SHALL have port iMod, input, 64: modulus, sampled only on an accepted iStart.
REQ-007 SHALL have port oBusy, output, 1: high in every state except IDLE.
REQ-008 SHALL have port oValid, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port oErr, output, 1: iMod was 0; qualified by oValid.
REQ-010 SHALL have port oK, output, 7: bit length of modulus; drives downstream iK.
REQ-011 SHALL have port oU, output, 128: floor(2^(2*oK) / iMod); drives downstream iU.

Function
REQ-012 SHALL use FSM states IDLE, NORM, DIV, DONE.
REQ-013 SHALL accept iStart only in IDLE, capturing iMod and moving to NORM; iStart in any other state is ignored.
REQ-014 NORM, one cycle: K is set to the index of the highest set bit of the captured modulus plus 1 (range 1..64); remainder r(65b) = 1, quotient q(128b) = 0, iteration counter = 2K; next state is DIV.
REQ-015 NORM with modulus 0: K = 0, U = 0, oErr = 1; next state is DONE, skipping DIV.
REQ-016 DIV, first cycle: compare only; if r >= mod then r = r - mod and q = 1.
REQ-017 DIV, each of the next 2K cycles: r' = 2r; q' = q<<1; if r' >= mod then r' = r' - mod and q' |= 1; counter decrements; the final iteration moves to DONE.
REQ-018 DIV SHALL last exactly 2K+1 cycles; r never exceeds 65 bits, and q never exceeds 2^65.
REQ-019 DONE, one cycle: oValid = 1; oK, oU and oErr are updated at DONE entry; next state is IDLE.
REQ-020 Latency: with iStart accepted at edge E0, oValid SHALL be high in the cycle after edge E0+2K+2 (E0+2 for a zero modulus).
REQ-021 oK, oU and oErr SHALL hold their last result until the next DONE entry.
REQ-022 iMod changing while oBusy is high SHALL have no effect.
REQ-023 iClr asserted in any state SHALL return the block to IDLE, clear all outputs and produce no oValid; iClr has priority over iStart in the same cycle.
REQ-024 iStart SHALL be accepted in the cycle immediately after DONE (back-to-back operation).

Reset
REQ-025 While iRstN is low at a rising iClk edge, the block SHALL enter state IDLE and take oBusy=0, oValid=0, oErr=0, oK=0, oU=0, with r, q and counter at 0.
REQ-026 Reset mid-operation SHALL abort the computation with no oValid pulse.
REQ-027 No output or state change SHALL occur asynchronously.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding and the constants DATA_W=64, K_W=7, U_W=128, R_W=65.
REQ-029 Leading-one detection SHALL be a separate combinational sub-module bit_length_64b (input 64b, output 7b, zero gives 0).
REQ-030 The compare/subtract datapath SHALL be at most one 65-bit subtractor per cycle; no multipliers are permitted.

Verification
REQ-031 iMod=1 -> oK=1, oU=4, oValid 4 edges after start, oErr=0.
REQ-032 iMod=7 -> oK=3, oU=9; iMod=2 -> oK=2, oU=8.
REQ-033 iMod=0xFFFFFFFF00000001 -> oK=64, oU=0x1_0000_0000_FFFF_FFFF, oValid 130 edges after start.
REQ-034 iMod=0 -> oErr=1, oK=0, oU=0, oValid 2 edges after start.
REQ-035 Start with iMod=7, then pulse iStart and change iMod at cycle 3 -> result unaffected (oU=9); then pulse iClr during DIV on a second run -> IDLE, no oValid, outputs 0.
REQ-036 Drive iRstN low at DIV cycle 10 of a 64-bit run -> all outputs 0 on the next edge, no oValid; a following start with iMod=7 yields oU=9.

Source files
------------

// File: rtl/barrett_precompute_64b_pkg.sv
// rtl/barrett_precompute_64b_pkg.sv - shared constants and FSM encoding for the Barrett precompute block
package barrett_precompute_64b_pkg;

   localparam int DATA_W = 64;
   localparam int K_W    = 7;
   localparam int U_W    = 128;
   localparam int R_W    = 65;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/barrett_precompute_64b_bit_length.sv
// rtl/barrett_precompute_64b_bit_length.sv - leading-one detector, returns bit length (0 for a zero input)
module bit_length_64b
   import barrett_precompute_64b_pkg::*;
(
   input  logic [DATA_W-1:0] value,
   output logic [K_W-1:0]    len
);

   always_comb begin
      len = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (value[i]) len = K_W'(i + 1);
      end
   end

endmodule

// File: rtl/barrett_precompute_64b.sv
// rtl/barrett_precompute_64b.sv - computes K = bitlen(mod) and U = floor(2^(2K)/mod) by restoring division
module barrett_precompute_64b #(
   parameter int DATA_W = 64
) (
   input  logic                                   iClk,
   input  logic                                   iRstN,
   input  logic                                   iClr,
   input  logic                                   iStart,
   input  logic [DATA_W-1:0]                      iMod,
   output logic                                   oBusy,
   output logic                                   oValid,
   output logic                                   oErr,
   output logic [barrett_precompute_64b_pkg::K_W-1:0] oK,
   output logic [barrett_precompute_64b_pkg::U_W-1:0] oU
);

   import barrett_precompute_64b_pkg::*;

   state_t             state;
   logic [DATA_W-1:0]  mod_q;
   logic [R_W-1:0]     r;
   logic [U_W-1:0]     q;
   logic [CNT_W-1:0]   cnt;
   logic [K_W-1:0]     k;
   logic               first;
   logic               err_wait;

   logic [K_W-1:0]     msb_len;
   logic [R_W-1:0]     r_cand;
   logic [R_W:0]       diff;
   logic               ge;
   logic [R_W-1:0]     r_next;
   logic [U_W-1:0]     q_next;

   bit_length_64b u_bit_length (
      .value (mod_q),
      .len   (msb_len)
   );

   // r stays below mod (< 2^64) after every step, so dropping r[64] on the shift loses nothing
   always_comb begin
      r_cand = first ? r : {r[R_W-2:0], 1'b0};
      diff   = {1'b0, r_cand} - {2'b00, mod_q};
      ge     = ~diff[R_W];
      r_next = ge ? diff[R_W-1:0] : r_cand;
      q_next = {q[U_W-2:0], ge};
   end

   assign oBusy = (state != IDLE);

   always_ff @(posedge iClk) begin
      if (!iRstN || iClr) begin
         state    <= IDLE;
         mod_q    <= '0;
         r        <= '0;
         q        <= '0;
         cnt      <= '0;
         k        <= '0;
         first    <= 1'b0;
         err_wait <= 1'b0;
         oValid   <= 1'b0;
         oErr     <= 1'b0;
         oK       <= '0;
         oU       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (iStart) begin
                  mod_q <= iMod;
                  state <= NORM;
               end
            end
            NORM: begin
               if (mod_q == '0) begin
                  k        <= '0;
                  oK       <= '0;
                  oU       <= '0;
                  oErr     <= 1'b1;
                  err_wait <= 1'b1;
                  state    <= DONE;
               end else begin
                  k     <= msb_len;
                  r     <= R_W'(1);
                  q     <= '0;
                  cnt   <= {msb_len, 1'b0};
                  first <= 1'b1;
                  state <= DIV;
               end
            end
            DIV: begin
               r <= r_next;
               q <= q_next;
               if (first) begin
                  first <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
                  if (cnt == CNT_W'(1)) begin
                     oValid <= 1'b1;
                     oK     <= k;
                     oU     <= q_next;
                     oErr   <= 1'b0;
                     state  <= DONE;
                  end
               end
            end
            DONE: begin
               // a zero modulus lingers one extra cycle so its pulse lands two edges after start
               if (err_wait) begin
                  err_wait <= 1'b0;
                  oValid   <= 1'b1;
               end else begin
                  oValid <= 1'b0;
                  state  <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_barrett_precompute_64b.sv
// tb/tb_barrett_precompute_64b.sv - self-checking bench for barrett_precompute_64b
module tb_barrett_precompute_64b;

   logic         iClk = 1'b0;
   logic         iRstN = 1'b0;
   logic         iClr = 1'b0;
   logic         iStart = 1'b0;
   logic [63:0]  iMod = '0;
   logic         oBusy;
   logic         oValid;
   logic         oErr;
   logic [6:0]   oK;
   logic [127:0] oU;

   int checks = 0;
   int errors = 0;

   barrett_precompute_64b #(.DATA_W(64)) dut (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iClr   (iClr),
      .iStart (iStart),
      .iMod   (iMod),
      .oBusy  (oBusy),
      .oValid (oValid),
      .oErr   (oErr),
      .oK     (oK),
      .oU     (oU)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic [63:0]  m;
      logic [6:0]   k;
      logic [127:0] u;
      logic         e;
      int           lat;
   } vec_t;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model(input logic [63:0] m, output logic [6:0] k, output logic [127:0] u,
                                 output logic e, output int lat);
      logic [255:0] num;
      int bl;
      bl = 0;
      while (bl < 64 && (m >> bl) != 64'd0) bl++;
      if (m == 64'd0) begin
         k = 7'd0; u = '0; e = 1'b1; lat = 2;
      end else begin
         k   = 7'(bl);
         num = 256'd1 << (2 * bl);
         u   = 128'(num / {192'd0, m});
         e   = 1'b0;
         lat = 2 * bl + 2;
      end
   endfunction

   // Waits for oValid, counting edges since the start edge; iMod is scrambled while busy
   task automatic wait_valid(input int already, output int lat);
      lat = -1;
      for (int n = already + 1; n <= 400; n++) begin
         @(posedge iClk); #1;
         iMod = {$urandom, $urandom};
         if (oValid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [63:0] m, input string tag, output logic [6:0] k_o,
                         output logic [127:0] u_o, output logic e_o, output int lat_o);
      iStart = 1'b1;
      iMod   = m;
      @(posedge iClk); #1;
      iStart = 1'b0;
      wait_valid(0, lat_o);
      if (lat_o < 0) check({tag, " valid_timeout"}, 128'(oValid), 128'd1);
      k_o = oK;
      u_o = oU;
      e_o = oErr;
      @(posedge iClk); #1;
      check({tag, " single_pulse"}, 128'(oValid), 128'd0);
      check({tag, " idle_after"}, 128'(oBusy), 128'd0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " busy"}, 128'(oBusy), 128'd0);
      check({tag, " valid"}, 128'(oValid), 128'd0);
      check({tag, " err"}, 128'(oErr), 128'd0);
      check({tag, " k"}, 128'(oK), 128'd0);
      check({tag, " u"}, oU, 128'd0);
   endtask

   initial begin
      vec_t         tbl[8];
      logic [6:0]   k_a, k_e;
      logic [127:0] u_a, u_e;
      logic         e_a, e_e;
      int           lat_a, lat_e, seen;
      logic [63:0]  m;

      tbl[0] = '{64'd1, 7'd1, 128'd4, 1'b0, 4};
      tbl[1] = '{64'd7, 7'd3, 128'd9, 1'b0, 8};
      tbl[2] = '{64'd2, 7'd2, 128'd8, 1'b0, 6};
      tbl[3] = '{64'd3, 7'd2, 128'd5, 1'b0, 6};
      tbl[4] = '{64'hFFFF_FFFF_0000_0001, 7'd64, 128'h1_0000_0000_FFFF_FFFF, 1'b0, 130};
      tbl[5] = '{64'd0, 7'd0, 128'd0, 1'b1, 2};
      tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 128'h1_0000_0000_0000_0001, 1'b0, 130};
      tbl[7] = '{64'h8000_0000_0000_0000, 7'd64, 128'h2_0000_0000_0000_0000, 1'b0, 130};

      repeat (2) @(posedge iClk);
      #1;
      check_zero("reset");
      iRstN = 1'b1;
      @(posedge iClk); #1;

      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i].m, $sformatf("vec%0d", i), k_a, u_a, e_a, lat_a);
         check($sformatf("vec%0d k", i), 128'(k_a), 128'(tbl[i].k));
         check($sformatf("vec%0d u", i), u_a, tbl[i].u);
         check($sformatf("vec%0d err", i), 128'(e_a), 128'(tbl[i].e));
         check($sformatf("vec%0d latency", i), 128'(lat_a), 128'(tbl[i].lat));
      end

      // start ignored while busy, iMod changes ignored
      iStart = 1'b1; iMod = 64'd7;
      @(posedge iClk); #1;
      iStart = 1'b0;
      repeat (2) @(posedge iClk);
      #1;
      iStart = 1'b1; iMod = 64'd0;
      @(posedge iClk); #1;
      iStart = 1'b0;
      wait_valid(3, lat_a);
      check("busy_start u", oU, 128'd9);
      check("busy_start k", 128'(oK), 128'd3);
      check("busy_start err", 128'(oErr), 128'd0);
      check("busy_start latency", 128'(lat_a), 128'd8);
      @(posedge iClk); #1;

      // clear during DIV, simultaneous with a start
      iStart = 1'b1; iMod = 64'd7;
      @(posedge iClk); #1;
      iStart = 1'b0;
      repeat (4) @(posedge iClk);
      #1;
      iClr = 1'b1; iStart = 1'b1; iMod = 64'd5;
      @(posedge iClk); #1;
      iClr = 1'b0; iStart = 1'b0;
      check_zero("clear");
      seen = 0;
      repeat (20) begin
         @(posedge iClk); #1;
         if (oValid) seen++;
      end
      check("clear no_valid", 128'(seen), 128'd0);
      check("clear stays_idle", 128'(oBusy), 128'd0);

      run_op(64'd2, "pre_reset", k_a, u_a, e_a, lat_a);
      check("pre_reset u", u_a, 128'd8);

      // reset at DIV cycle 10 of a 64-bit run
      iStart = 1'b1; iMod = 64'hFFFF_FFFF_0000_0001;
      @(posedge iClk); #1;
      iStart = 1'b0;
      repeat (10) @(posedge iClk);
      #1;
      iRstN = 1'b0;
      @(posedge iClk); #1;
      check_zero("mid_reset");
      iRstN = 1'b1;
      seen = 0;
      repeat (140) begin
         @(posedge iClk); #1;
         if (oValid) seen++;
      end
      check("mid_reset no_valid", 128'(seen), 128'd0);
      run_op(64'd7, "post_reset", k_a, u_a, e_a, lat_a);
      check("post_reset u", u_a, 128'd9);
      check("post_reset k", 128'(k_a), 128'd3);

      repeat (6) @(posedge iClk);
      #1;
      check("hold u", oU, 128'd9);
      check("hold k", 128'(oK), 128'd3);

      for (int i = 0; i < 15; i++) begin
         m = {$urandom, $urandom} >> $urandom_range(0, 63);
         model(m, k_e, u_e, e_e, lat_e);
         run_op(m, $sformatf("rnd%0d", i), k_a, u_a, e_a, lat_a);
         check($sformatf("rnd%0d m=%0h k", i, m), 128'(k_a), 128'(k_e));
         check($sformatf("rnd%0d m=%0h u", i, m), u_a, u_e);
         check($sformatf("rnd%0d m=%0h err", i, m), 128'(e_a), 128'(e_e));
         check($sformatf("rnd%0d m=%0h latency", i, m), 128'(lat_a), 128'(lat_e));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
